seq_chunk_adder: RTL
====================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle 64-bit two's-complement adder/subtractor for the Y86 ALU, the additive counterpart of the combinational subtract path.
//  Adds (or subtracts) CHUNK_W bits per clock through a carry register and produces Y86 condition codes (ZF, SF, OF) plus carry-out.
//  Sits between decode/execute operand latches and the CC register; operands arrive and results leave on valid/ready handshakes.
// PARAMETERS
//  WIDTH    64  operand/result width in bits
//  CHUNK_W  8   bits processed per RUN cycle; must divide WIDTH (legal: 1,2,4,8,16,32,64)
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, sub are valid this cycle
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  signed operand A
//  b          in   WIDTH  signed operand B
//  sub        in   1      0: y = a + b; 1: y = a - b (a + ~b + 1)
//  out_valid  out  1      y and flags valid; held until accepted
//  out_ready  in   1      consumer accepts result this cycle
//  y          out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  zf         out  1      y == 0
//  sf         out  1      y[WIDTH-1]
//  of         out  1      signed overflow
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; in_ready=0 while rst_n low, 1 on first clk after release;
//   out_valid=0; y=0; cout=0; zf=0; sf=0; of=0; carry reg, chunk index cleared.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. in_valid&in_ready -> latch a, b_eff = sub ? ~b : b, carry=sub, idx=0, sign bits of a,b_eff; go RUN.
//  RUN: in_ready=0. Each cycle: {c, y[idx*CHUNK_W +: CHUNK_W]} = a_chunk + b_eff_chunk + carry; carry<=c; idx++.
//   After chunk WIDTH/CHUNK_W-1: cout=c, flags computed from full y; go DONE.
//   Latency: accept edge + WIDTH/CHUNK_W RUN cycles; out_valid rises on the edge ending the last chunk (64/8 -> 8 cycles).
//  DONE: out_valid=1; y/flags stable. out_valid&out_ready -> IDLE, out_valid=0 next cycle.
//   No new operand accepted in the same cycle as result handoff (in_ready=0 in DONE); throughput 1 op per N+2 cycles.
//  Flags: zf = (y==0); sf = y[WIDTH-1];
//   of = (a[W-1]==b_eff[W-1]) && (y[W-1]!=a[W-1]) -- uses b_eff so one rule covers add and sub.
//  sub with b = most-negative: ~b+1 wraps; of follows rule above (e.g. 0 - 0x8000..0 -> y=0x8000..0, of=1).
//  Operands/sub ignored outside IDLE accept; changes on inputs during RUN do not affect result.
//  in_valid with out_ready both high in DONE: result handed off, operands NOT taken (held by producer).
//  rst_n asserted mid-RUN or DONE: abort, all outputs to reset values immediately; partial result discarded.
//  CHUNK_W=WIDTH: single RUN cycle; behaviour otherwise identical.
//  y updated chunk-wise during RUN; value only meaningful when out_valid=1.
// TESTING
//  1) a=5, b=7, sub=0, CHUNK_W=8 -> after 8 RUN cycles out_valid=1, y=12, zf=0 sf=0 of=0 cout=0.
//  2) a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> y=0x8000_0000_0000_0000, sf=1, of=1, cout=0.
//  3) a=3, b=3, sub=1 -> y=0, zf=1, sf=0, of=0, cout=1; a=0, b=1, sub=1 -> y=all-ones, sf=1, cout=0.
//  4) a=-1, b=1, sub=0 -> y=0, zf=1, cout=1 (carry through all chunks), of=0.
//  5) hold out_ready=0 for 5 cycles in DONE -> out_valid and y stable, in_ready=0; then accept -> IDLE, next op accepted.
//  6) pull rst_n low at RUN chunk 3 -> out_valid=0, y=0 immediately; after release new op 2+2 -> y=4, correct.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle two's-complement adder/subtractor for the Y86 ALU.
// Each RUN cycle handles CHUNK_W bits and passes the carry to the next cycle
// through a register. At the end it produces y, cout and the ZF/SF/OF flags.
// Operands come in and results go out on valid/ready handshakes.
module seq_chunk_adder #(
  parameter int WIDTH   = 64,
  parameter int CHUNK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_d;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               cout_q;
  logic               zf_q;
  logic               sf_q;
  logic               of_q;
  logic               of_d;
  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CHUNK_W:0]   chunk_sum;
  int                 base;

  // Add the current chunk and merge it into the result. Overflow compares the
  // sign of b_eff, so one rule covers both add and subtract.
  always_comb begin
    base      = int'(idx_q) * CHUNK_W;
    a_chunk   = a_q[base +: CHUNK_W];
    b_chunk   = b_q[base +: CHUNK_W];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK_W + 1)'(carry_q);
    y_d       = y_q;
    y_d[base +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
    of_d      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM with registered handshake outputs, operands, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          y_q     <= y_d;
          carry_q <= chunk_sum[CHUNK_W];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= chunk_sum[CHUNK_W];
            zf_q        <= (y_d == '0);
            sf_q        <= y_d[WIDTH-1];
            of_q        <= of_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule
